// File: rtl/fact_accel_pkg.sv
// fact_accel_pkg: register offsets, FSM states and STATUS bit positions
// shared by the factorial accelerator and its datapath.
`default_nettype none

package fact_accel_pkg;

  localparam logic [1:0] FACT_N   = 2'b00;
  localparam logic [1:0] FACT_GO  = 2'b01;
  localparam logic [1:0] FACT_ST  = 2'b10;
  localparam logic [1:0] FACT_RES = 2'b11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  localparam int DONE = 0;
  localparam int ERR  = 1;
  localparam int BUSY = 2;

endpackage

`default_nettype wire

// File: rtl/fact_accel_dp.sv
// fact_dp: countdown/product registers for the iterative factorial,
// one WIDTH x N_BITS multiply per step.
`default_nettype none

module fact_dp #(
  parameter int WIDTH  = 32,
  parameter int N_BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [N_BITS-1:0] n,
  output logic              gt1,
  output logic [WIDTH-1:0]  prod
);

  logic [N_BITS-1:0] cnt;
  logic [WIDTH-1:0]  prod_next;

  // Zero-extending cnt keeps the product at WIDTH bits; higher bits are dropped.
  assign prod_next = prod * {{(WIDTH-N_BITS){1'b0}}, cnt};
  assign gt1       = cnt > N_BITS'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      prod <= '0;
    end else if (load) begin
      cnt  <= n;
      prod <= WIDTH'(1);
    end else if (step) begin
      cnt  <= cnt - N_BITS'(1);
      prod <= prod_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fact_accel.sv
// fact_accel: memory-mapped factorial peripheral (N, GO, STATUS, RESULT)
// with an iterative multiply FSM and a combinational read mux.
`default_nettype none

module fact_accel
  import fact_accel_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int N_BITS = 4,
  parameter int MAX_N  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [1:0]       a,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] rd
);

  localparam logic [N_BITS-1:0] MAX_N_V = N_BITS'(MAX_N);

  state_t            state, state_next;
  logic [N_BITS-1:0] n_reg;
  logic              go_reg;
  logic              done, err, busy;
  logic [WIDTH-1:0]  result_reg;
  logic [WIDTH-1:0]  prod;
  logic              gt1;
  logic              start, n_ok;
  logic              load, step, finish, err_start;
  logic [2:0]        status;
  logic              unused_wd;

  assign unused_wd = ^wd[WIDTH-1:N_BITS];

  // A GO write only launches from IDLE; during CALC it merely updates go_reg.
  assign start = we && (a == FACT_GO) && wd[0] && (state == IDLE);
  assign n_ok  = n_reg <= MAX_N_V;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && n_ok) state_next = CALC;
      CALC:    if (!gt1)          state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    err_start = 1'b0;
    case (state)
      IDLE: begin
        load      = start && n_ok;
        err_start = start && !n_ok;
      end
      CALC: begin
        step   = gt1;
        finish = !gt1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_reg      <= '0;
      go_reg     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      result_reg <= '0;
    end else begin
      if (we && (a == FACT_N))  n_reg  <= wd[N_BITS-1:0];
      if (we && (a == FACT_GO)) go_reg <= wd[0];
      if (load) begin
        done <= 1'b0;
        err  <= 1'b0;
        busy <= 1'b1;
      end else if (err_start) begin
        done       <= 1'b1;
        err        <= 1'b1;
        busy       <= 1'b0;
        result_reg <= '0;
      end else if (finish) begin
        done       <= 1'b1;
        busy       <= 1'b0;
        result_reg <= prod;
      end
    end
  end

  fact_dp #(
    .WIDTH  (WIDTH),
    .N_BITS (N_BITS)
  ) u_dp (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .n    (n_reg),
    .gt1  (gt1),
    .prod (prod)
  );

  always_comb begin
    status       = '0;
    status[DONE] = done;
    status[ERR]  = err;
    status[BUSY] = busy;
  end

  always_comb begin
    rd = '0;
    case (a)
      FACT_N:   rd = {{(WIDTH-N_BITS){1'b0}}, n_reg};
      FACT_GO:  rd = {{(WIDTH-1){1'b0}}, go_reg};
      FACT_ST:  rd = {{(WIDTH-3){1'b0}}, status};
      FACT_RES: rd = result_reg;
      default:  rd = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_fact_accel.sv
// tb_fact_accel: scoreboard bench; expected register reads are queued at
// issue time and a negedge monitor pops and compares them against rd.
`default_nettype none

module tb_fact_accel;
  import fact_accel_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we  = 1'b0;
  logic [1:0]  a   = 2'b00;
  logic [31:0] wd  = '0;
  logic [31:0] rd;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  bit   obs_valid = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;

  fact_accel #(.WIDTH(32), .N_BITS(4), .MAX_N(12)) dut (
    .clk (clk),
    .rst (rst),
    .we  (we),
    .a   (a),
    .wd  (wd),
    .rd  (rd)
  );

  always #5 clk = ~clk;

  // Reference: n! truncated to 32 bits, error when n exceeds 12.
  function automatic logic [31:0] fact_ref(input int n);
    longint p = 1;
    for (int i = 2; i <= n; i++) p = p * i;
    return p[31:0];
  endfunction

  always @(negedge clk) begin
    if (obs_valid) begin
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL scoreboard_empty: read at a=%0d got %h with nothing expected", a, rd);
      end else begin
        exp_t e;
        e = sb.pop_front();
        compared++;
        if (rd !== e.val) begin
          mismatched++;
          $display("FAIL %s: got %h expected %h (t=%0t)", e.name, rd, e.val, $time);
        end
      end
    end
  end

  task automatic check(input logic [1:0] off, input logic [31:0] val, input string nm);
    a  = off;
    we = 1'b0;
    sb.push_back('{nm, val});
    obs_valid = 1'b1;
    @(negedge clk);
    #1 obs_valid = 1'b0;
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d);
    a  = off;
    wd = d;
    we = 1'b1;
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  task automatic run_job(input int n, input bit interfere);
    bit          is_err;
    int          lat;
    int          k;
    logic [31:0] res;
    is_err = (n > 12);
    lat    = (n > 1) ? n : 1;
    res    = is_err ? 32'd0 : fact_ref(n);
    wr(FACT_N, 32'(n));
    wr(FACT_GO, 32'd1);
    if (is_err) begin
      check(FACT_ST, 32'b011, $sformatf("err_status_n%0d", n));
      check(FACT_RES, 32'd0, $sformatf("err_result_n%0d", n));
      check(FACT_ST, 32'b011, $sformatf("err_nobusy_n%0d", n));
      return;
    end
    check(FACT_ST, 32'b100, $sformatf("busy_after_go_n%0d", n));
    k = 0;
    if (interfere) begin
      wr(FACT_N, 32'd3);
      wr(FACT_GO, 32'd1);
      k = 2;
    end
    while (k < lat - 1) begin
      @(posedge clk);
      #1 k++;
    end
    if (lat > 1) check(FACT_ST, 32'b100, $sformatf("busy_before_done_n%0d", n));
    @(posedge clk);
    #1;
    check(FACT_ST, 32'b001, $sformatf("done_status_n%0d", n));
    check(FACT_RES, res, $sformatf("result_n%0d", n));
    if (interfere) begin
      check(FACT_N, 32'd3, "interfere_n_reg");
      check(FACT_GO, 32'd1, "interfere_go_reg");
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    check(FACT_N,   32'd0, "reset_n");
    check(FACT_GO,  32'd0, "reset_go");
    check(FACT_ST,  32'd0, "reset_status");
    check(FACT_RES, 32'd0, "reset_result");

    run_job(5, 1'b0);
    run_job(0, 1'b0);
    run_job(1, 1'b0);
    run_job(12, 1'b0);
    run_job(13, 1'b0);
    run_job(15, 1'b0);
    run_job(6, 1'b1);

    for (int i = 0; i < 10; i++) run_job(int'($urandom_range(0, 15)), 1'b0);

    // Abort a long run with an asynchronous reset between clock edges.
    wr(FACT_N, 32'd10);
    wr(FACT_GO, 32'd1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    check(FACT_ST,  32'd0, "midrun_reset_status");
    check(FACT_RES, 32'd0, "midrun_reset_result");
    check(FACT_N,   32'd0, "midrun_reset_n");
    check(FACT_GO,  32'd0, "midrun_reset_go");
    @(posedge clk);
    #1 rst = 1'b0;
    run_job(4, 1'b0);

    a  = FACT_N;
    wd = 32'd7;
    we = 1'b0;
    @(posedge clk);
    #1;
    check(FACT_N, 32'd4, "no_write_when_we_low");

    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
